// File: rtl/sccomp_dbg_pkg.sv
// sccomp_dbg_pkg: shared state, command and halt-cause encodings for the
// single-cycle CPU debug controller.
package sccomp_dbg_pkg;
   typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DUMP_RD, S_DUMP_OUT} state_e;
   typedef enum logic [1:0] {OP_RUN = 2'd0, OP_HALT = 2'd1, OP_STEP = 2'd2, OP_DUMP = 2'd3} op_e;
   typedef enum logic [1:0] {C_RESET = 2'd0, C_REQUEST = 2'd1, C_BREAKPOINT = 2'd2, C_WATCHDOG = 2'd3} cause_e;
endpackage

// File: rtl/sccomp_dbg_dump.sv
// sccomp_dbg_dump: register-file walker; reads registers 0..31 one at a time
// and presents each on a valid/ready output port.
module sccomp_dbg_dump
   import sccomp_dbg_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        start_i,
   input  logic        dump_ready_i,
   input  logic [31:0] reg_data_i,
   output logic        busy_o,
   output logic        dump_valid_o,
   output logic [4:0]  reg_sel_o,
   output logic [4:0]  dump_idx_o,
   output logic [31:0] dump_data_o
);
   state_e      phase_q, phase_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] data_q, data_d;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_q <= S_IDLE;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         phase_q <= phase_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end
   always_comb begin
      phase_d = phase_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (phase_q)
         S_DUMP_RD: begin
            data_d  = reg_data_i;
            phase_d = S_DUMP_OUT;
         end
         S_DUMP_OUT: if (dump_ready_i) begin
            idx_d   = idx_q + 5'd1;
            phase_d = (idx_q == 5'd31) ? S_IDLE : S_DUMP_RD;
         end
         default: if (start_i) begin
            idx_d   = '0;
            phase_d = S_DUMP_RD;
         end
      endcase
   end
   assign busy_o       = phase_q != S_IDLE;
   assign dump_valid_o = phase_q == S_DUMP_OUT;
   assign reg_sel_o    = idx_q;
   assign dump_idx_o   = idx_q;
   assign dump_data_o  = data_q;
endmodule

// File: rtl/sccomp_dbg_ctrl.sv
// sccomp_dbg_ctrl: run/halt/step/dump debug controller for a single-cycle CPU.
// Define SCCOMP_DBG_WDOG_EN to enable the MAX_CYCLES watchdog halt.
module sccomp_dbg_ctrl
   import sccomp_dbg_pkg::*;
#(
   parameter int unsigned MAX_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic [31:0] pc,
   output logic        cpu_en,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_data,
   output logic        dump_valid,
   input  logic        dump_ready,
   output logic [4:0]  dump_idx,
   output logic [31:0] dump_data,
   output logic        halted,
   output logic [1:0]  halt_cause,
   output logic [31:0] cycle_cnt
);
`ifdef SCCOMP_DBG_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   state_e      mode_q, mode_d;
   cause_e      cause_q, cause_d;
   logic [31:0] bp_q, bp_d, cnt_q, cnt_d, cyc_q, cyc_d;
   logic        first_q, first_d;
   logic        busy, acc, exec, bp_hit, req_hit, wd_hit, stop;
   // The walker owns DUMP_RD/DUMP_OUT; mode_q stays IDLE while it is busy.
   sccomp_dbg_dump u_dump (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (acc && !exec && cmd_op == OP_DUMP),
      .dump_ready_i (dump_ready),
      .reg_data_i   (reg_data),
      .busy_o       (busy),
      .dump_valid_o (dump_valid),
      .reg_sel_o    (reg_sel),
      .dump_idx_o   (dump_idx),
      .dump_data_o  (dump_data)
   );
   assign cmd_ready  = !busy;
   assign acc        = cmd_valid && cmd_ready;
   assign exec       = mode_q != S_IDLE;
   assign bp_hit     = mode_q == S_RUN && !first_q && pc == bp_q;
   assign req_hit    = exec && acc && cmd_op == OP_HALT;
   assign wd_hit     = WD_EN && exec && cyc_q >= 32'(MAX_CYCLES);
   assign stop       = bp_hit || req_hit || wd_hit;
   assign cpu_en     = exec && !stop;
   assign halted     = !exec && !busy;
   assign halt_cause = cause_q;
   assign cycle_cnt  = cyc_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q  <= S_IDLE;
         cause_q <= C_RESET;
         bp_q    <= '0;
         cnt_q   <= '0;
         cyc_q   <= '0;
         first_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         cause_q <= cause_d;
         bp_q    <= bp_d;
         cnt_q   <= cnt_d;
         cyc_q   <= cyc_d;
         first_q <= first_d;
      end
   end
   always_comb begin
      mode_d  = mode_q;
      cause_d = cause_q;
      bp_d    = bp_q;
      cnt_d   = cnt_q;
      cyc_d   = cyc_q;
      first_d = first_q;
      if (!exec) begin
         if (acc && cmd_op == OP_RUN) begin
            mode_d  = S_RUN;
            bp_d    = cmd_arg;
            cyc_d   = '0;
            first_d = 1'b1;
         end else if (acc && cmd_op == OP_STEP && cmd_arg != '0) begin
            mode_d = S_STEP;
            cnt_d  = cmd_arg;
            cyc_d  = '0;
         end
      end else if (stop) begin
         mode_d  = S_IDLE;
         cause_d = bp_hit ? C_BREAKPOINT : req_hit ? C_REQUEST : C_WATCHDOG;
      end else begin
         cyc_d   = cyc_q + {31'd0, ~&cyc_q};
         first_d = 1'b0;
         cnt_d   = (mode_q == S_STEP) ? cnt_q - 32'd1 : cnt_q;
         // Last step retires this cycle; leave before a further instruction runs.
         if (mode_q == S_STEP && cnt_q == 32'd1) begin
            mode_d  = S_IDLE;
            cause_d = C_REQUEST;
         end
      end
   end
endmodule

// File: doc/sccomp_dbg_ctrl.md
SCCOMP_DBG_CTRL -- requirements
Module: sccomp_dbg_ctrl

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 1000: watchdog limit, in CPU-enabled cycles per RUN/STEP session.
REQ-002 SHALL have port clk  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port rstn  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (00 RUN, 01 HALT, 10 STEP, 11 DUMP), cmd_arg in 32 (RUN: breakpoint PC; STEP: step count).
REQ-005 SHALL have port pc  in  32  current CPU PC.
REQ-006 SHALL have port cpu_en  out  1  CPU clock enable; one instruction retires per cycle with cpu_en=1.
REQ-007 SHALL have ports reg_sel out 5 and reg_data in 32: the CPU register-file debug read port, combinational read.
REQ-008 SHALL have ports dump_valid out 1, dump_ready in 1, dump_idx out 5, dump_data out 32.
REQ-009 SHALL have ports halted out 1, halt_cause out 2 (0 RESET, 1 REQUEST, 2 BREAKPOINT, 3 WATCHDOG) and cycle_cnt out 32.

Function
REQ-010 SHALL implement states IDLE, RUN, STEP, DUMP_RD, DUMP_OUT; halted=1 exactly in IDLE.
REQ-011 SHALL drive cmd_ready=1 in IDLE, RUN and STEP, and 0 in DUMP_RD and DUMP_OUT; a command is accepted when cmd_valid and cmd_ready are both 1.
REQ-012 SHALL, in IDLE: RUN -> RUN (latch bp=cmd_arg, clear cycle_cnt); STEP with arg>0 -> STEP (latch count, clear cycle_cnt); STEP with arg=0 and HALT are no-ops; DUMP -> DUMP_RD with index 0.
REQ-013 SHALL, in RUN/STEP, treat accepted RUN, STEP and DUMP commands as ignored; an accepted HALT -> IDLE with cause REQUEST, and cpu_en=0 in that cycle.
REQ-014 SHALL drive cpu_en combinationally: 1 in RUN/STEP unless a halt condition is true in that cycle; 0 in all other states.
REQ-015 SHALL, in RUN from the second RUN cycle onward, treat pc==bp as a halt condition: cpu_en=0 that cycle -> IDLE with cause BREAKPOINT; the instruction at bp does not execute.
REQ-016 SHALL skip the breakpoint compare in the first RUN cycle, so a RUN resumed at pc==bp executes that instruction.
REQ-017 SHALL, in STEP, ignore the breakpoint, decrement the count on each cpu_en cycle, and go to IDLE with cause REQUEST after the cycle in which the count reaches 0; exactly N instructions execute.
REQ-018 SHALL increment cycle_cnt on every cpu_en=1 cycle, saturating at 2^32-1, and hold it in IDLE.
REQ-019 SHALL resolve simultaneous halt conditions with priority BREAKPOINT > REQUEST > WATCHDOG.
REQ-020 SHALL, during a dump: DUMP_RD drives reg_sel=index and registers reg_data -> DUMP_OUT; DUMP_OUT holds dump_valid=1 with dump_idx/dump_data stable until dump_ready=1.
REQ-021 SHALL, on a DUMP_OUT handshake, go to DUMP_RD with index+1, or to IDLE after index 31; halt_cause is unchanged by a dump.

Reset
REQ-022 SHALL, while rstn=0: state IDLE, cpu_en 0, reg_sel 0, dump_valid 0, dump_idx 0, dump_data 0, cycle_cnt 0, halt_cause RESET, halted 1.
REQ-023 SHALL abort any RUN, STEP or dump immediately on rstn=0 mid-operation; no partial dump resumes.

Configuration
REQ-024 SHALL, with SCCOMP_DBG_WDOG_EN defined, halt RUN/STEP with cause WATCHDOG when cycle_cnt reaches MAX_CYCLES (cpu_en=0 in that cycle); without it, no watchdog halt exists and MAX_CYCLES is unused.

Structure
REQ-025 SHALL place the state enum, cmd_op codes and halt_cause codes in shared package sccomp_dbg_pkg.
REQ-026 SHALL implement the register walker (DUMP_RD/DUMP_OUT, index, output register) as sub-module sccomp_dbg_dump.

Verification
REQ-027 SHALL cover: RUN bp=0x48 from PC 0 with sequential code -> exactly 18 cpu_en cycles, halt at pc=0x48, cause 2, cycle_cnt 18.
REQ-028 SHALL cover: RUN bp=0x48 again at pc=0x48 -> 0x48 executes, no immediate re-halt.
REQ-029 SHALL cover: STEP arg=3 -> exactly 3 cpu_en cycles, cause 1; STEP arg=0 -> no cpu_en pulse.
REQ-030 SHALL cover: DUMP with dump_ready toggling every other cycle -> 32 beats, idx 0..31 in order, data equal to the register-file contents, data stable while stalled, cmd_ready=0 throughout.
REQ-031 SHALL cover: with SCCOMP_DBG_WDOG_EN and MAX_CYCLES=1000, RUN on an infinite loop -> halt after 1000 cycles, cause 3; HALT arriving in the same cycle as a breakpoint -> cause 2.
REQ-032 SHALL cover: rstn pulsed low during a dump at index 10 -> dump_valid 0 and state IDLE immediately, cause 0.
